// File: rtl/seq_pkg.sv
// Shared types and constants for the sequence player/checker.
package seq_pkg;

    localparam int unsigned SYM_W   = 2;
    localparam int unsigned NUM_SYM = 9;
    localparam int unsigned SEQ_W   = SYM_W * NUM_SYM;

    localparam logic [SYM_W-1:0] SYM_0 = 2'd0;
    localparam logic [SYM_W-1:0] SYM_1 = 2'd1;
    localparam logic [SYM_W-1:0] SYM_2 = 2'd2;

    typedef enum logic [2:0] {
        StIdle,
        StShowOn,
        StShowGap,
        StWaitKey,
        StPass,
        StFail
    } state_e;

    // Symbol idx of a packed sequence; symbol 0 sits in the low bits.
    function automatic logic [SYM_W-1:0] sym_at(logic [SEQ_W-1:0] seq, logic [3:0] idx);
        logic [SEQ_W-1:0] sh;
        sh = seq >> (SYM_W * idx);
        return sh[SYM_W-1:0];
    endfunction

    function automatic int unsigned max3(int unsigned a, int unsigned b, int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/seq_player_checker_phase_timer.sv
// Loadable down-counter; expire_o pulses for one cycle when the loaded
// duration has elapsed (count reaches 1). A load wins over counting.
module phase_timer #(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             load_i,
    input  logic [Width-1:0] value_i,
    output logic             expire_o
);

    logic [Width-1:0] cnt_q;

    // Count down to zero and park there until reloaded.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= value_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - Width'(1);
        end
    end

    assign expire_o = (cnt_q == Width'(1));

endmodule

// File: rtl/seq_player_checker.sv
// Latches a 9-symbol sequence, replays it to the display, then checks the
// player's entries and reports score / pass / fail.
// Optional feature: define SEQ_TIMEOUT_EN to fail a game when no entry
// arrives within TIMEOUT_CYCLES while waiting for a key.
module seq_player_checker
    import seq_pkg::*;
#(
    parameter int unsigned SHOW_CYCLES    = 25_000_000,
    parameter int unsigned GAP_CYCLES     = 12_500_000,
    parameter int unsigned TIMEOUT_CYCLES = 250_000_000
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             load_i,
    input  logic [SEQ_W-1:0] seq_in_i,
    input  logic             key_valid_i,
    input  logic [SYM_W-1:0] key_sym_i,
    output logic             show_valid_o,
    output logic [SYM_W-1:0] show_sym_o,
    output logic             key_ready_o,
    output logic [3:0]       score_o,
    output logic             done_o,
    output logic             pass_o,
    output logic             fail_o
);

    localparam int unsigned CntW    = $clog2(max3(SHOW_CYCLES, GAP_CYCLES, TIMEOUT_CYCLES) + 1);
    localparam logic [3:0]  LastIdx = 4'(NUM_SYM - 1);

    state_e           state_q;
    logic [SEQ_W-1:0] seq_q;
    logic [3:0]       idx_q;
    logic [3:0]       score_q;
    logic             show_valid_q, key_ready_q, done_q, pass_q, fail_q;
    logic [SYM_W-1:0] show_sym_q;

    logic             tmr_load;
    logic [CntW-1:0]  tmr_value;
    logic             tmr_expire;
    logic             key_match;

    assign key_match = (key_sym_i == sym_at(seq_q, idx_q));

    phase_timer #(
        .Width (CntW)
    ) u_timer (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .load_i   (tmr_load),
        .value_i  (tmr_value),
        .expire_o (tmr_expire)
    );

    // Timer reloads alongside each state transition that starts a timed phase.
    always_comb begin
        tmr_load  = 1'b0;
        tmr_value = CntW'(SHOW_CYCLES);
        unique case (state_q)
            StIdle, StPass, StFail: tmr_load = load_i;
            StShowOn: begin
                if (tmr_expire) begin
                    tmr_load  = 1'b1;
                    tmr_value = CntW'(GAP_CYCLES);
                end
            end
            StShowGap: begin
                if (tmr_expire) begin
                    if (idx_q != LastIdx) begin
                        tmr_load = 1'b1;
                    end else begin
`ifdef SEQ_TIMEOUT_EN
                        tmr_load  = 1'b1;
                        tmr_value = CntW'(TIMEOUT_CYCLES);
`endif
                    end
                end
            end
            StWaitKey: begin
`ifdef SEQ_TIMEOUT_EN
                if (key_valid_i) begin
                    tmr_load  = 1'b1;
                    tmr_value = CntW'(TIMEOUT_CYCLES);
                end
`endif
            end
            default: ;
        endcase
    end

    // Main FSM; outputs are registered alongside the state they decode.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= StIdle;
            seq_q        <= '0;
            idx_q        <= '0;
            score_q      <= '0;
            show_valid_q <= 1'b0;
            show_sym_q   <= SYM_0;
            key_ready_q  <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            fail_q       <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StPass, StFail: begin
                    if (load_i) begin
                        state_q      <= StShowOn;
                        seq_q        <= seq_in_i;
                        idx_q        <= '0;
                        score_q      <= '0;
                        show_valid_q <= 1'b1;
                        show_sym_q   <= sym_at(seq_in_i, 4'd0);
                        done_q       <= 1'b0;
                        pass_q       <= 1'b0;
                        fail_q       <= 1'b0;
                    end
                end
                StShowOn: begin
                    if (tmr_expire) begin
                        state_q      <= StShowGap;
                        show_valid_q <= 1'b0;
                        show_sym_q   <= SYM_0;
                    end
                end
                StShowGap: begin
                    if (tmr_expire) begin
                        if (idx_q == LastIdx) begin
                            state_q     <= StWaitKey;
                            idx_q       <= '0;
                            key_ready_q <= 1'b1;
                        end else begin
                            state_q      <= StShowOn;
                            idx_q        <= idx_q + 4'd1;
                            show_valid_q <= 1'b1;
                            show_sym_q   <= sym_at(seq_q, idx_q + 4'd1);
                        end
                    end
                end
                StWaitKey: begin
                    if (key_valid_i) begin
                        if (key_match) begin
                            score_q <= (score_q == 4'(NUM_SYM)) ? score_q : score_q + 4'd1;
                            if (idx_q == LastIdx) begin
                                state_q     <= StPass;
                                key_ready_q <= 1'b0;
                                done_q      <= 1'b1;
                                pass_q      <= 1'b1;
                            end else begin
                                idx_q <= idx_q + 4'd1;
                            end
                        end else begin
                            state_q     <= StFail;
                            key_ready_q <= 1'b0;
                            done_q      <= 1'b1;
                            fail_q      <= 1'b1;
                        end
                    end
`ifdef SEQ_TIMEOUT_EN
                    else if (tmr_expire) begin
                        state_q     <= StFail;
                        key_ready_q <= 1'b0;
                        done_q      <= 1'b1;
                        fail_q      <= 1'b1;
                    end
`endif
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign show_valid_o = show_valid_q;
    assign show_sym_o   = show_sym_q;
    assign key_ready_o  = key_ready_q;
    assign score_o      = score_q;
    assign done_o       = done_q;
    assign pass_o       = pass_q;
    assign fail_o       = fail_q;

endmodule

// File: tb/tb_seq_player_checker.sv
// Directed + randomized bench for seq_player_checker with short phase timings.
module tb_seq_player_checker;

    localparam int unsigned SHOW = 4;
    localparam int unsigned GAP  = 2;
    localparam int unsigned TMO  = 10;
    localparam int unsigned PER  = SHOW + GAP;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        load = 1'b0;
    logic [17:0] seq_in = '0;
    logic        key_valid = 1'b0;
    logic [1:0]  key_sym = '0;
    logic        show_valid;
    logic [1:0]  show_sym;
    logic        key_ready;
    logic [3:0]  score;
    logic        done, pass, fail;

    int checks = 0;
    int errors = 0;

    seq_player_checker #(
        .SHOW_CYCLES    (SHOW),
        .GAP_CYCLES     (GAP),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .load_i       (load),
        .seq_in_i     (seq_in),
        .key_valid_i  (key_valid),
        .key_sym_i    (key_sym),
        .show_valid_o (show_valid),
        .show_sym_o   (show_sym),
        .key_ready_o  (key_ready),
        .score_o      (score),
        .done_o       (done),
        .pass_o       (pass),
        .fail_o       (fail)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: the player's view of the sequence as a list of symbols.
    function automatic int ref_sym(input logic [17:0] s, input int i);
        return int'((s / (18'd1 << (2 * i))) % 4);
    endfunction

    function automatic logic [17:0] rand_seq();
        logic [17:0] s;
        s = '0;
        for (int i = 0; i < 9; i++) s = s | (18'($urandom_range(2)) << (2 * i));
        return s;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_outs"}, {show_valid, show_sym, key_ready, score, done, pass, fail}, 32'd0);
    endtask

    // Load a sequence and verify the whole presentation, cycle by cycle,
    // with random key_valid noise that must be ignored.
    task automatic load_and_present(input logic [17:0] s);
        int exp_v, exp_s;
        seq_in = s;
        load = 1'b1;
        tick();
        load = 1'b0;
        check("restart_clear", {done, pass, fail, score}, 32'd0);
        for (int t = 0; t < 9 * PER; t++) begin
            exp_v = ((t % PER) < SHOW) ? 1 : 0;
            exp_s = (exp_v == 1) ? ref_sym(s, t / PER) : 0;
            check("present", {key_ready, show_valid, show_sym, score, done},
                  {20'd0, 1'b0, 1'(exp_v), 2'(exp_s), 4'd0, 1'b0});
            key_valid = 1'($urandom_range(1));
            key_sym = 2'($urandom_range(3));
            tick();
        end
        key_valid = 1'b0;
        check("key_ready_rise", {key_ready, show_valid, done}, 32'b100);
    endtask

    task automatic press(input logic [1:0] sym);
        key_valid = 1'b1;
        key_sym = sym;
        tick();
        key_valid = 1'b0;
    endtask

    logic [17:0] s;
    int          exp_score;
    bit          ended, ok;
    logic [1:0]  k;

    initial begin
        // Reset state
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check_all_zero("reset");

        // Presentation and correct entry, three cycles apart
        s = 18'h2_4921;
        load_and_present(s);
        for (int i = 0; i < 9; i++) begin
            if (i == 4) begin
                // load in WAIT_KEY must be ignored
                seq_in = ~s;
                load = 1'b1;
                tick();
                load = 1'b0;
                check("load_ignored", {key_ready, show_valid, score}, {27'd0, 1'b1, 1'b0, 4'd4});
            end
            press(2'(ref_sym(s, i)));
            check("correct_score", score, 32'(i + 1));
            check("correct_flags", {done, pass, fail, key_ready},
                  (i == 8) ? 32'b1100 : 32'b0001);
            tick();
            tick();
        end

        // Restart from PASS, then mismatch on the third entry
        s = rand_seq();
        load_and_present(s);
        press(2'(ref_sym(s, 0)));
        press(2'(ref_sym(s, 1)));
        press(2'((ref_sym(s, 2) + 1 + $urandom_range(2)) % 4));
        check("mismatch_score", score, 32'd2);
        check("mismatch_flags", {done, pass, fail, key_ready}, 32'b1010);
        press(2'(ref_sym(s, 2)));
        press(2'(ref_sym(s, 3)));
        check("after_fail_score", score, 32'd2);
        check("after_fail_flags", {done, pass, fail}, 32'b101);

        // Randomized games with back-to-back or spaced entries
        for (int g = 0; g < 6; g++) begin
            s = rand_seq();
            load_and_present(s);
            exp_score = 0;
            ended = 1'b0;
            for (int i = 0; i < 9 && !ended; i++) begin
                ok = ($urandom_range(7) != 0);
                k = ok ? 2'(ref_sym(s, i)) : 2'((ref_sym(s, i) + 1 + $urandom_range(2)) % 4);
                press(k);
                if (ok) exp_score++;
                ended = !ok || (i == 8);
                check("rand_score", score, 32'(exp_score));
                check("rand_flags", {done, pass, fail, key_ready},
                      {28'd0, ended, ended && ok, !ok, !ended});
                for (int w = $urandom_range(2); w > 0; w--) tick();
            end
        end

        // Reset mid-SHOW_ON wins over a concurrent load
        s = rand_seq();
        seq_in = s;
        load = 1'b1;
        tick();
        load = 1'b0;
        tick();
        check("pre_reset_show", show_valid, 32'd1);
        reset = 1'b1;
        load = 1'b1;
        tick();
        reset = 1'b0;
        load = 1'b0;
        check_all_zero("mid_reset");
        tick();
        check_all_zero("mid_reset_hold");

        // Entry timeout
        load_and_present(rand_seq());
`ifdef SEQ_TIMEOUT_EN
        for (int c = 1; c < TMO; c++) begin
            tick();
            check("timeout_early", {fail, done, key_ready}, 32'b001);
        end
        tick();
        check("timeout_fail", {fail, done, pass, key_ready}, 32'b1100);
`else
        for (int c = 0; c < 1000; c++) tick();
        check("no_timeout", {fail, done, key_ready}, 32'b001);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
